// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed little-endian byte stream into the
// instruction memory, one write per 32-bit word, and holds the core in reset
// until the whole program has been written.
module imem_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);

    // Word counter needs one extra bit so a full-depth count is representable.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [8:0] DEPTH_B = 9'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    n_q, n_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          idx_q, idx_d;
    logic [23:0]         buf_q, buf_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;

    logic                xfer;
    logic [CNT_W-1:0]    last_word;
    logic [2:0]          lane_en;

    assign in_ready  = (state_q == S_LEN) || (state_q == S_DATA);
    assign xfer      = in_valid && in_ready;
    assign last_word = n_q - CNT_W'(1);

    // Byte lanes 0..2 are buffered; lane 3 completes the word directly.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            assign lane_en[gi] = xfer && (state_q == S_DATA) && (idx_q == 2'(gi));
            assign buf_d[gi*8 +: 8] = lane_en[gi] ? in_byte : buf_q[gi*8 +: 8];
        end
    endgenerate

    // Next-state and datapath updates for the load sequence.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (xfer) begin
                    if ((in_byte == 8'd0) || ({1'b0, in_byte} > DEPTH_B)) begin
                        state_d = S_ERR;
                    end else begin
                        n_d     = in_byte[CNT_W-1:0];
                        cnt_d   = '0;
                        idx_d   = 2'd0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        wdata_d = {in_byte, buf_q};
                        addr_d  = cnt_q[ADDR_W-1:0];
                        we_d    = 1'b1;
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == last_word) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            buf_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q == S_LEN) || (state_q == S_DATA);
    assign done      = (state_q == S_DONE);
    assign err       = (state_q == S_ERR);
    assign cpu_hold  = (state_q != S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: drives the byte stream on the falling
// edge and samples outputs on the falling edge, away from the active edge.
`timescale 1ns/1ps
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_hold;

    int checks_cnt = 0;
    int errors_cnt = 0;
    int wr_count   = 0;
    int b2b_viol   = 0;
    logic       prev_we   = 1'b0;
    logic [5:0] prev_addr = '0;

    imem_loader #(.DEPTH(64), .ADDR_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cpu_hold  (cpu_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: counts pulses and flags a repeated write to one address.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_count = wr_count + 1;
            if (prev_we && (prev_addr == mem_addr)) b2b_viol = b2b_viol + 1;
        end
        prev_we   = mem_we;
        prev_addr = mem_addr;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt = checks_cnt + 1;
        if (obs !== exp) begin
            errors_cnt = errors_cnt + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_mem_we"},   32'(mem_we),   32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_wdata"},    mem_wdata,     32'd0);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_done"},     32'(done),     32'd0);
        check({tag, "_err"},      32'(err),      32'd0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_byte  = b;
        @(negedge clk);
        in_valid = 1'b0;
        in_byte  = 8'hxx;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Sends one word LSB first with 'gap' idle cycles between bytes, then
    // checks the write pulse in the cycle right after the 4th byte.
    task automatic send_word(input logic [31:0] w, input int gap, input logic [5:0] exp_addr);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8]);
            if (k < 3) idle(gap);
        end
        check("word_we",   32'(mem_we),   32'd1);
        check("word_addr", 32'(mem_addr), 32'(exp_addr));
        check("word_data", mem_wdata,     w);
    endtask

    int base;
    logic [31:0] w;

    initial begin
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
        idle(2);
        check_reset_outputs("rst_hold");
        rst = 1'b1;
        idle(2);
        check_reset_outputs("rst_idle");
        $display("T1 reset state checked");

        // Single word, back-to-back bytes.
        pulse_start();
        check("t1_ready_after_start", 32'(in_ready), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        base = wr_count;
        send_byte(8'h01); send_byte(8'h83); send_byte(8'h00); send_byte(8'h80);
        check("t1_no_we_early", 32'(mem_we), 32'd0);
        send_byte(8'h00);
        check("t1_we",       32'(mem_we),   32'd1);
        check("t1_addr",     32'(mem_addr), 32'd0);
        check("t1_data",     mem_wdata,     32'h00800083);
        check("t1_done",     32'(done),     32'd1);
        check("t1_cpu_hold", 32'(cpu_hold), 32'd0);
        check("t1_ready",    32'(in_ready), 32'd0);
        idle(1);
        check("t1_we_drop",   32'(mem_we),   32'd0);
        check("t1_data_hold", mem_wdata,     32'h00800083);
        check("t1_writes",    32'(wr_count - base), 32'd1);
        $display("T2 single word load checked");

        // N=3 with valid toggled every other cycle.
        pulse_start();
        base = wr_count;
        send_byte(8'd3); idle(1);
        send_word(32'h00000033, 1, 6'd0); idle(1);
        send_word(32'h00000073, 1, 6'd1); idle(1);
        send_word(32'hFFF18193, 1, 6'd2);
        check("t2_done",   32'(done), 32'd1);
        idle(2);
        check("t2_writes", 32'(wr_count - base), 32'd3);
        $display("T3 three word toggled load checked");

        // Full depth.
        pulse_start();
        base = wr_count;
        send_byte(8'd64);
        for (int i = 0; i < 64; i++) begin
            w = 32'hA5000000 + 32'(i) * 32'h00010203;
            send_word(w, 0, 6'(i));
            if (i < 63) check("t3_not_done", 32'(done), 32'd0);
        end
        check("t3_done",      32'(done),     32'd1);
        check("t3_last_addr", 32'(mem_addr), 32'd63);
        idle(2);
        check("t3_writes", 32'(wr_count - base), 32'd64);
        $display("T4 64 word load checked");

        // Oversized length.
        pulse_start();
        base = wr_count;
        send_byte(8'd65);
        check("t4_err",      32'(err),      32'd1);
        check("t4_ready",    32'(in_ready), 32'd0);
        check("t4_cpu_hold", 32'(cpu_hold), 32'd1);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        idle(2);
        check("t4_err_stay", 32'(err), 32'd1);
        check("t4_writes",   32'(wr_count - base), 32'd0);
        $display("T5 N=65 error checked");

        // Zero length, then recovery.
        pulse_start();
        send_byte(8'd0);
        check("t5_err",      32'(err),      32'd1);
        check("t5_cpu_hold", 32'(cpu_hold), 32'd1);
        pulse_start();
        check("t5_err_clr", 32'(err), 32'd0);
        send_byte(8'd1);
        send_word(32'hDEADBEEF, 0, 6'd0);
        check("t5_done", 32'(done), 32'd1);
        check("t5_err0", 32'(err),  32'd0);
        $display("T6 N=0 error and recovery checked");

        // Reset mid-load after 6 of 8 data bytes.
        pulse_start();
        base = wr_count;
        send_byte(8'd2);
        send_word(32'h12345678, 0, 6'd0);
        send_byte(8'hAA); send_byte(8'hBB);
        #2 rst = 1'b0;
        #1 check_reset_outputs("t6_async");
        check("t6_writes", 32'(wr_count - base), 32'd1);
        idle(2);
        rst = 1'b1;
        idle(3);
        check("t6_cpu_hold", 32'(cpu_hold), 32'd1);
        check("t6_no_more_writes", 32'(wr_count - base), 32'd1);
        $display("T7 mid-load reset checked");

        // Start during DATA is ignored.
        pulse_start();
        base = wr_count;
        send_byte(8'd2);
        send_word(32'h0000A001, 0, 6'd0);
        pulse_start();
        check("t7_still_busy", 32'(busy), 32'd1);
        send_word(32'h0000B002, 0, 6'd1);
        check("t7_done", 32'(done), 32'd1);
        idle(1);
        check("t7_writes", 32'(wr_count - base), 32'd2);
        // Start in DONE restarts and overwrites address 0.
        pulse_start();
        check("t7_hold_back", 32'(cpu_hold), 32'd1);
        check("t7_done_clr",  32'(done),     32'd0);
        send_byte(8'd1);
        send_word(32'hCAFEF00D, 0, 6'd0);
        check("t7_done2", 32'(done), 32'd1);
        idle(1);
        check("b2b_same_addr", 32'(b2b_viol), 32'd0);
        $display("T8 start in DATA/DONE checked");

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

    // Global time bound so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
